// File: rtl/pool_flatten.sv
// pool_flatten: 2x2 / stride-2 signed max-pooling in front of the FC flatten memory.
//
// Takes a raster stream (channel-major, then row-major, then column). It pools each 2x2 window
// using a half-row line buffer and writes every pooled value into the FC flatten memory through
// flat_we/flat_value/flat_addr. Once the whole map is written, it holds fc_enable high until the
// FC reports fc_all_end. It then pulses flat_done and returns to idle.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   start                   one-cycle pulse that begins a new map (honoured only when idle)
//   in_valid/in_ready       input handshake; in_value is the signed sample
//   flat_we/value/addr      flatten memory write port, one write per pooled output
//   fc_enable, fc_all_end   FC start level / FC finished
//   flat_done               one-cycle pulse when the FC run ends
//   argmax_addr/argmax_idx  winner-position readback (registered, one cycle latency)
//
// Optional feature: define POOL_ARGMAX_EN to store a 2-bit winner code per pooled output
// (0=r0c0, 1=r0c1, 2=r1c0, 3=r1c1). Without it, argmax_idx is tied to 0.

module pool_flatten #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IMG_W  = 4,
   parameter int unsigned IMG_H  = 14,
   parameter int unsigned CH     = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_value,
   output logic              flat_we,
   output logic [DATA_W-1:0] flat_value,
   output logic [15:0]       flat_addr,
   output logic              fc_enable,
   input  logic              fc_all_end,
   output logic              flat_done,
   input  logic [15:0]       argmax_addr,
   output logic [1:0]        argmax_idx
);

   localparam int unsigned HALF_W   = IMG_W / 2;
   localparam int unsigned FLAT_LEN = CH * (IMG_H / 2) * HALF_W;
   localparam int unsigned LB_AW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;

   localparam logic [15:0] HALF_W16 = 16'(HALF_W);
   localparam logic [15:0] PLANE16  = 16'((IMG_H / 2) * HALF_W);
   localparam logic [15:0] COL_LAST = 16'(IMG_W - 1);
   localparam logic [15:0] ROW_LAST = 16'(IMG_H - 1);
   localparam logic [15:0] CH_LAST  = 16'(CH - 1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StStream = 2'd1;
   localparam logic [1:0] StFlush  = 2'd2;
   localparam logic [1:0] StRun    = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [15:0] col_q, col_d, row_q, row_d, ch_q, ch_d;

   logic signed [DATA_W-1:0] in_s;
   logic signed [DATA_W-1:0] tmp_q, tmp_d;
   logic [1:0]               tmp_arg_q, tmp_arg_d;
   logic signed [DATA_W-1:0] linebuf_q [HALF_W];
   logic [1:0]               lb_arg_q [HALF_W];
   logic [LB_AW-1:0]         lb_idx;
   logic signed [DATA_W-1:0] lb_rd, lb_wdata;
   logic [1:0]               lb_rd_arg, lb_warg;
   logic                     lb_we;

   logic              flat_we_q, flat_we_d;
   logic [DATA_W-1:0] flat_value_q, flat_value_d;
   logic [15:0]       flat_addr_q, flat_addr_d;
   logic [1:0]        flat_arg_q, flat_arg_d;
   logic              flat_done_q, flat_done_d;

   logic accept, last_smp, gt_tmp, gt_lb;

   assign in_s      = $signed(in_value);
   assign accept    = in_valid && (state_q == StStream);
   assign last_smp  = (col_q == COL_LAST) && (row_q == ROW_LAST) && (ch_q == CH_LAST);
   assign lb_idx    = LB_AW'(col_q >> 1);
   assign lb_rd     = linebuf_q[lb_idx];
   assign lb_rd_arg = lb_arg_q[lb_idx];
   // Strict greater-than: on ties the earlier-scanned sample keeps the slot.
   assign gt_tmp    = in_s > tmp_q;
   assign gt_lb     = in_s > lb_rd;

   always_comb begin
      state_d     = state_q;
      flat_done_d = 1'b0;
      case (state_q)
         StIdle:   if (start) state_d = StStream;
         StStream: if (accept && last_smp) state_d = StFlush;
         StFlush:  state_d = StRun;
         StRun: begin
            if (fc_all_end) begin
               state_d     = StIdle;
               flat_done_d = 1'b1;
            end
         end
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      ch_d  = ch_q;
      if (state_q == StIdle && start) begin
         col_d = '0;
         row_d = '0;
         ch_d  = '0;
      end else if (accept) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
               row_d = '0;
               ch_d  = ch_q + 16'd1;
            end else begin
               row_d = row_q + 16'd1;
            end
         end else begin
            col_d = col_q + 16'd1;
         end
      end
   end

   // Window reduction: even row folds each column pair into the line buffer, odd row merges the
   // buffered row-0 maximum with the row-1 pair and emits the result.
   always_comb begin
      tmp_d        = tmp_q;
      tmp_arg_d    = tmp_arg_q;
      lb_we        = 1'b0;
      lb_wdata     = tmp_q;
      lb_warg      = tmp_arg_q;
      flat_we_d    = 1'b0;
      flat_value_d = flat_value_q;
      flat_addr_d  = flat_addr_q;
      flat_arg_d   = flat_arg_q;
      if (accept) begin
         unique case ({row_q[0], col_q[0]})
            2'b00: begin
               tmp_d     = in_s;
               tmp_arg_d = 2'd0;
            end
            2'b01: begin
               lb_we    = 1'b1;
               lb_wdata = gt_tmp ? in_s : tmp_q;
               lb_warg  = gt_tmp ? 2'd1 : tmp_arg_q;
            end
            2'b10: begin
               tmp_d     = gt_lb ? in_s : lb_rd;
               tmp_arg_d = gt_lb ? 2'd2 : lb_rd_arg;
            end
            2'b11: begin
               flat_we_d    = 1'b1;
               flat_value_d = gt_tmp ? in_value : tmp_q;
               flat_arg_d   = gt_tmp ? 2'd3 : tmp_arg_q;
               flat_addr_d  = ch_q * PLANE16 + (row_q >> 1) * HALF_W16 + (col_q >> 1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         col_q        <= '0;
         row_q        <= '0;
         ch_q         <= '0;
         tmp_q        <= '0;
         tmp_arg_q    <= '0;
         flat_we_q    <= 1'b0;
         flat_value_q <= '0;
         flat_addr_q  <= '0;
         flat_arg_q   <= '0;
         flat_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         ch_q         <= ch_d;
         tmp_q        <= tmp_d;
         tmp_arg_q    <= tmp_arg_d;
         flat_we_q    <= flat_we_d;
         flat_value_q <= flat_value_d;
         flat_addr_q  <= flat_addr_d;
         flat_arg_q   <= flat_arg_d;
         flat_done_q  <= flat_done_d;
      end
   end

   // Line buffer contents are fully rewritten on every even row, so no reset is needed.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         linebuf_q[lb_idx] <= lb_wdata;
         lb_arg_q[lb_idx]  <= lb_warg;
      end
   end

   assign in_ready   = (state_q == StStream);
   assign flat_we    = flat_we_q;
   assign flat_value = flat_value_q;
   assign flat_addr  = flat_addr_q;
   assign fc_enable  = (state_q == StRun);
   assign flat_done  = flat_done_q;

`ifdef POOL_ARGMAX_EN
   localparam int unsigned FLAT_AW = (FLAT_LEN > 1) ? $clog2(FLAT_LEN) : 1;

   logic [1:0] argmax_mem [FLAT_LEN];
   logic [1:0] argmax_idx_q;

   // Written alongside flat_we; contents persist across runs until overwritten.
   always_ff @(posedge clk) begin
      if (flat_we_q) argmax_mem[FLAT_AW'(flat_addr_q)] <= flat_arg_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         argmax_idx_q <= '0;
      end else if (argmax_addr < 16'(FLAT_LEN)) begin
         argmax_idx_q <= argmax_mem[FLAT_AW'(argmax_addr)];
      end else begin
         argmax_idx_q <= '0;
      end
   end

   assign argmax_idx = argmax_idx_q;
`else
   logic unused_argmax;
   assign unused_argmax = ^{argmax_addr, flat_arg_q};
   assign argmax_idx    = 2'd0;
`endif

endmodule

// File: tb/tb_pool_flatten.sv
// Scoreboard bench for pool_flatten: expected writes are queued as stimulus is issued and popped
// by per-instance monitors whenever flat_we is seen. A second instance covers CH=2, 4x4 maps.

module tb_pool_flatten;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0, start2 = 1'b0;
   logic        in_valid = 1'b0, fc_all_end = 1'b0;
   logic [15:0] in_value = '0, argmax_addr = '0, argmax_addr2 = '0;

   logic        in_ready, flat_we, fc_enable, flat_done;
   logic [15:0] flat_value, flat_addr;
   logic [1:0]  argmax_idx;
   logic        in_ready2, flat_we2, fc_enable2, flat_done2;
   logic [15:0] flat_value2, flat_addr2;
   logic [1:0]  argmax_idx2;

   int checks = 0, failures = 0;
   logic [31:0] exp_q[$], exp2_q[$];
   logic [15:0] v2 [8] = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd21, 16'd23, 16'd29, 16'd31};

   always #5 clk = ~clk;

   pool_flatten dut (
      .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_value(in_value), .flat_we(flat_we), .flat_value(flat_value), .flat_addr(flat_addr),
      .fc_enable(fc_enable), .fc_all_end(fc_all_end), .flat_done(flat_done),
      .argmax_addr(argmax_addr), .argmax_idx(argmax_idx)
   );

   pool_flatten #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .CH(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
      .in_value(in_value), .flat_we(flat_we2), .flat_value(flat_value2), .flat_addr(flat_addr2),
      .fc_enable(fc_enable2), .fc_all_end(fc_all_end), .flat_done(flat_done2),
      .argmax_addr(argmax_addr2), .argmax_idx(argmax_idx2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitors
   logic        we_prev = 1'b0, en_prev = 1'b0, we2_prev = 1'b0, en2_prev = 1'b0;
   logic [15:0] addr_prev = '0, addr2_prev = '0;

   always @(negedge clk) begin
      if (flat_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_we: addr %0d value 0x%0h with no write expected",
                     flat_addr, flat_value);
         end else begin
            chk("write", {flat_addr, flat_value}, exp_q.pop_front());
         end
         chk("we_with_enable", 32'(fc_enable), 32'd0);
      end
      if (fc_enable && !en_prev)
         chk("enable_rise", {15'd0, we_prev, addr_prev}, {15'd0, 1'b1, 16'd13});
      we_prev   <= flat_we;
      addr_prev <= flat_addr;
      en_prev   <= fc_enable;
   end

   always @(negedge clk) begin
      if (flat_we2) begin
         if (exp2_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_we2: addr %0d value 0x%0h with no write expected",
                     flat_addr2, flat_value2);
         end else begin
            chk("write2", {flat_addr2, flat_value2}, exp2_q.pop_front());
         end
         chk("we2_with_enable", 32'(fc_enable2), 32'd0);
      end
      if (fc_enable2 && !en2_prev)
         chk("enable2_rise", {15'd0, we2_prev, addr2_prev}, {15'd0, 1'b1, 16'd7});
      we2_prev   <= flat_we2;
      addr2_prev <= flat_addr2;
      en2_prev   <= fc_enable2;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ramp();
      for (int k = 0; k < 7; k++)
         for (int j = 0; j < 2; j++)
            exp_q.push_back({16'(2 * k + j), 16'(8 * k + 2 * j + 5)});
   endtask

   task automatic do_start(input bit sel);
      if (sel) start2 = 1'b1; else start = 1'b1;
      tick();
      start  = 1'b0;
      start2 = 1'b0;
   endtask

   // mode 0: ramp 0..n-1; mode 1: -1 at sample 0, -100 elsewhere. poke drives start and
   // fc_all_end mid-stream, both of which must be ignored.
   task automatic stream(input int n, input int mode, input bit gaps, input bit poke);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            in_value = 16'hDEAD;
            tick();
         end
         in_valid = 1'b1;
         if (mode == 0) in_value = 16'(i);
         else in_value = (i == 0) ? 16'hFFFF : 16'hFF9C;
         if (poke && i == 10) begin
            start      = 1'b1;
            fc_all_end = 1'b1;
         end
         tick();
         start      = 1'b0;
         fc_all_end = 1'b0;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_run(input bit sel);
      int n = 0;
      while (!(sel ? fc_enable2 : fc_enable) && n < 200) begin
         tick();
         n++;
      end
      chk("enable_reached", 32'(sel ? fc_enable2 : fc_enable), 32'd1);
      chk("writes_drained", 32'(sel ? exp2_q.size() : exp_q.size()), 32'd0);
   endtask

   task automatic end_run(input bit sel);
      repeat (20) tick();
      chk("enable_held", 32'(sel ? fc_enable2 : fc_enable), 32'd1);
      fc_all_end = 1'b1;
      tick();
      fc_all_end = 1'b0;
      chk("enable_drop", 32'(sel ? fc_enable2 : fc_enable), 32'd0);
      chk("done_pulse", 32'(sel ? flat_done2 : flat_done), 32'd1);
      chk("idle_not_ready", 32'(sel ? in_ready2 : in_ready), 32'd0);
      tick();
      chk("done_single", 32'(sel ? flat_done2 : flat_done), 32'd0);
   endtask

   task automatic check_argmax(input logic [1:0] code);
`ifdef POOL_ARGMAX_EN
      for (int a = 0; a < 14; a++) begin
         argmax_addr = 16'(a);
         tick();
         chk("argmax", 32'(argmax_idx), 32'(code));
      end
`else
      argmax_addr = 16'd5;
      tick();
      chk("argmax_tied", 32'(argmax_idx), 32'(code & 2'b00));
`endif
   endtask

   task automatic check_zero(input string name);
      chk(name, {26'd0, flat_we, fc_enable, flat_done, in_ready, argmax_idx}, 32'd0);
      chk({name, "_data"}, {flat_addr, flat_value}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      chk("reset_state2", {27'd0, flat_we2, fc_enable2, flat_done2, in_ready2, 1'b0}, 32'd0);
      reset_n = 1'b1;
      tick();

      // Ramp with continuous valid
      push_ramp();
      do_start(1'b0);
      chk("stream_ready", 32'(in_ready), 32'd1);
      stream(56, 0, 1'b0, 1'b0);
      wait_run(1'b0);
      check_argmax(2'd3);
      end_run(1'b0);

      // Same ramp with gaps; stray start and fc_all_end mid-stream
      push_ramp();
      do_start(1'b0);
      stream(56, 0, 1'b1, 1'b1);
      wait_run(1'b0);
      end_run(1'b0);

      // Signed compare and tie handling
      exp_q.push_back({16'd0, 16'hFFFF});
      for (int a = 1; a < 14; a++) exp_q.push_back({16'(a), 16'hFF9C});
      do_start(1'b0);
      stream(56, 1, 1'b0, 1'b0);
      wait_run(1'b0);
      check_argmax(2'd0);
      end_run(1'b0);

      // Reset mid-stream, then a clean rerun
      push_ramp();
      do_start(1'b0);
      stream(30, 0, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      check_zero("midreset");
      exp_q.delete();
      repeat (3) tick();
      reset_n  = 1'b1;
      in_valid = 1'b1;
      repeat (10) tick();
      chk("no_start_ready", {30'd0, in_ready, fc_enable}, 32'd0);
      in_valid = 1'b0;
      push_ramp();
      do_start(1'b0);
      stream(56, 0, 1'b0, 1'b0);
      wait_run(1'b0);
      end_run(1'b0);

      // Two channels, 4x4 maps
      for (int a = 0; a < 8; a++) exp2_q.push_back({16'(a), v2[a]});
      do_start(1'b1);
      stream(32, 0, 1'b0, 1'b0);
      wait_run(1'b1);
      end_run(1'b1);

      chk("queues_empty", 32'(exp_q.size() + exp2_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pool_flatten.md
Name: pool_flatten

Overview:
- Upstream neighbour of the FC top module.
- Accepts the last conv stage's feature maps as a raster stream, performs 2x2/stride-2 max-pooling with a half-row line buffer, and writes the pooled results into the FC flatten input memory through a we/value/addr port.
- When the map is fully written it raises the FC enable and holds it until the FC reports all_end.

Parameters:
- DATA_W, 16, signed sample width; equals the FC flat_value width.
- IMG_W, 4, input map width; must be even.
- IMG_H, 14, input map height; must be even.
- CH, 1, number of channels. Flatten length is CH*(IMG_H/2)*(IMG_W/2), 14 at defaults, matching FC FRT_CELL.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse from the controller that begins a new map.
- in_valid, input, 1: input sample valid.
- in_ready, output, 1: block can accept a sample.
- in_value, input, DATA_W: signed sample; order is channel-major, then row-major, then column.
- flat_we, output, 1: FC flatten write enable.
- flat_value, output, DATA_W: pooled value.
- flat_addr, output, 16: flatten address.
- fc_enable, output, 1: FC start level.
- fc_all_end, input, 1: FC finished.
- flat_done, output, 1: one-cycle pulse when the FC run ends.
- argmax_addr, input, 16: argmax read address.
- argmax_idx, output, 2: winner position within the 2x2 window.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, line buffer contents don't-care.
- States:
  - IDLE: start goes to STREAM and clears col/row/ch counters. Other inputs ignored.
  - STREAM: in_ready=1. A sample is accepted when in_valid & in_ready. After the last sample (ch=CH-1, row=IMG_H-1, col=IMG_W-1) is accepted, go to FLUSH.
  - FLUSH: one cycle, in_ready=0; the last flat_we is issued here. Next state RUN.
  - RUN: fc_enable=1 held. When fc_all_end=1, clear fc_enable, pulse flat_done for one cycle, return to IDLE.
- start is ignored in every state except IDLE.
- Pooling datapath, by position of the accepted sample:
  - Even row, even col: tmp <= value.
  - Even row, odd col: linebuf[col/2] <= max(tmp, value).
  - Odd row, even col: tmp <= max(linebuf[col/2], value).
  - Odd row, odd col: result = max(tmp, value), registered onto flat_value with flat_we=1 the next cycle.
  - flat_addr = ch*(IMG_H/2)*(IMG_W/2) + (row/2)*(IMG_W/2) + col/2.
- Max is a signed compare. On ties the earlier-scanned sample wins (replace only on strict greater).
- flat_we is high exactly one cycle per pooled output; there are exactly CH*(IMG_H/2)*(IMG_W/2) writes per run.
- Latency: flat_we is one cycle after acceptance of the odd-row/odd-col sample.
- in_valid gaps: counters and datapath hold; no spurious writes.
- Counter wrap: col wraps at IMG_W-1 and increments row; row wraps at IMG_H-1 and increments ch. No cross-channel state leak, because tmp and linebuf are rewritten on each even row.
- fc_enable first rises the cycle after the last flat_we, never concurrently with it.
- reset_n low mid-operation: immediate return to reset values. No writes or enable until the next start.
- fc_all_end outside RUN is ignored.

Optional Feature:
- Macro POOL_ARGMAX_EN.
- Defined:
  - Each pooled output also stores a 2-bit winner code in an argmax memory of flatten length, written on the same cycle as flat_we. Codes: 0=(r0,c0), 1=(r0,c1), 2=(r1,c0), 3=(r1,c1).
  - argmax_idx is registered: it presents the entry for argmax_addr one cycle after the address is applied. It is used later for pool backprop routing of fc_err_prop.
  - Contents persist until overwritten by the next run.
- Not defined: no argmax memory; argmax_idx tied to 0 and argmax_addr unused.

Test Plan:
- Defaults, reset, start, stream in_value=0..55 with in_valid always 1: 14 writes, addr k*2+j carries 8k+2j+5 (addr0=5, addr1=7, addr13=55). fc_enable rises the cycle after the addr13 write. With POOL_ARGMAX_EN, all argmax entries are 3.
- Same stream with in_valid low on every other cycle: identical 14 writes, values and order; no extra flat_we.
- Signed values: all samples -100 except row0/col0=-1. Result: addr0=-1, other addrs=-100. argmax entry 0 = 0; all-tie blocks also give argmax 0.
- fc_all_end pulsed 20 cycles into RUN: fc_enable drops the next cycle, flat_done pulses once, state IDLE. A start pulse asserted during STREAM produces no effect.
- reset_n low after 30 samples: all outputs 0 immediately. A new start plus a full stream then gives the same result as the first scenario.
- CH=2, IMG_W=4, IMG_H=4, stream 0..31: 8 writes, addrs 0..7, values 5,7,13,15,21,23,29,31.
